// File: rtl/schmidl_cox_pkg.sv
// Shared types and register defaults for the Schmidl-Cox frame acquisition path.
package schmidl_cox_pkg;

    localparam int SAMPLE_W = 32;
    localparam int METRIC_W = 32;

    localparam int unsigned REG_PACKET_SIZE_DEFAULT = 64;
    localparam logic [31:0] REG_THRESHOLD_DEFAULT   = 32'h0020_0000;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        PLATEAU,
        CAPTURE,
        HOLDOFF
    } sc_state_t;

endpackage

// File: rtl/axi_fifo_flop2.sv
// Single register slice for a valid/ready stream; one cycle latency, full throughput.
// Upstream is ready whenever the slot is empty or draining this cycle; output is held while stalled.
module axi_fifo_flop2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] up_dat,
    input  logic             up_last,
    input  logic             up_vld,
    output logic             up_rdy,
    output logic [WIDTH-1:0] dn_dat,
    output logic             dn_last,
    output logic             dn_vld,
    input  logic             dn_rdy
);

    assign up_rdy = !dn_vld || dn_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_vld  <= 1'b0;
            dn_dat  <= '0;
            dn_last <= 1'b0;
        end else if (up_rdy) begin
            dn_vld <= up_vld;
            if (up_vld) begin
                dn_dat  <= up_dat;
                dn_last <= up_last;
            end
        end
    end

endmodule

// File: rtl/schmidl_cox_frame_ctrl.sv
// Arms on a metric threshold crossing, validates the plateau, then forwards one framed burst.
// Captured samples appear one cycle after acceptance; input ready follows the output slot.
module schmidl_cox_frame_ctrl
    import schmidl_cox_pkg::*;
#(
    parameter int MIN_PLATEAU = 16,
    parameter int MAX_PLATEAU = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                ce_clk,
    input  logic                ce_rst,
    input  logic                cfg_enable,
    input  logic [CNT_W-1:0]    cfg_packet_size,
    input  logic [METRIC_W-1:0] cfg_threshold,
    input  logic [CNT_W-1:0]    cfg_holdoff,
    input  logic [SAMPLE_W-1:0] s_axis_tdata,
    input  logic [METRIC_W-1:0] s_axis_tuser,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [SAMPLE_W-1:0] m_axis_tdata,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                det_pulse,
    output logic                busy,
    output logic [31:0]         frame_count
);

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] PLAT_MIN    = CNT_W'(MIN_PLATEAU);
    localparam logic [CNT_W-1:0] PLAT_MAX_M1 = CNT_W'(MAX_PLATEAU - 1);

    sc_state_t           state;
    sc_state_t           after_frame;
    logic [CNT_W-1:0]    size_q;
    logic [CNT_W-1:0]    holdoff_q;
    logic [METRIC_W-1:0] thr_q;
    logic [CNT_W-1:0]    plat_cnt;
    logic [CNT_W-1:0]    sent_cnt;
    logic [CNT_W-1:0]    hold_cnt;
    logic                beat;
    logic                above;
    logic                plat_accept;
    logic                fwd_vld;
    logic                fwd_last;

    assign beat  = s_axis_tvalid && s_axis_tready;
    assign above = s_axis_tuser >= thr_q;
    assign busy  = (state != IDLE);

    // The plateau either ends on its first low beat (long enough) or is cut at the max length.
    assign plat_accept = (state == PLATEAU) &&
                         (above ? (plat_cnt >= PLAT_MAX_M1) : (plat_cnt >= PLAT_MIN));

    assign fwd_vld  = s_axis_tvalid && ((state == CAPTURE) || (plat_accept && size_q != '0));
    assign fwd_last = (state == CAPTURE) ? (sent_cnt == size_q - ONE) : (size_q == ONE);

    // A zero hold-off skips HOLDOFF entirely so no sample is dropped after the frame.
    always_comb begin
        after_frame = HOLDOFF;
        if (holdoff_q == '0)
            after_frame = cfg_enable ? ARMED : IDLE;
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state       <= IDLE;
            size_q      <= CNT_W'(REG_PACKET_SIZE_DEFAULT);
            thr_q       <= REG_THRESHOLD_DEFAULT;
            holdoff_q   <= '0;
            plat_cnt    <= '0;
            sent_cnt    <= '0;
            hold_cnt    <= '0;
            det_pulse   <= 1'b0;
            frame_count <= '0;
        end else begin
            det_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_enable) begin
                        size_q    <= cfg_packet_size;
                        thr_q     <= cfg_threshold;
                        holdoff_q <= cfg_holdoff;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (beat) begin
                        if (!cfg_enable) begin
                            state <= IDLE;
                        end else if (above) begin
                            state    <= PLATEAU;
                            plat_cnt <= ONE;
                        end
                    end
                end
                PLATEAU: begin
                    if (beat) begin
                        if (plat_accept) begin
                            det_pulse   <= 1'b1;
                            frame_count <= frame_count + 32'd1;
                            plat_cnt    <= '0;
                            hold_cnt    <= '0;
                            if (size_q == '0 || size_q == ONE) begin
                                state <= after_frame;
                            end else begin
                                state    <= CAPTURE;
                                sent_cnt <= ONE;
                            end
                        end else if (above) begin
                            plat_cnt <= plat_cnt + ONE;
                        end else begin
                            state    <= ARMED;
                            plat_cnt <= '0;
                        end
                    end
                end
                CAPTURE: begin
                    if (beat) begin
                        if (sent_cnt == size_q - ONE) begin
                            state    <= after_frame;
                            sent_cnt <= '0;
                            hold_cnt <= '0;
                        end else begin
                            sent_cnt <= sent_cnt + ONE;
                        end
                    end
                end
                HOLDOFF: begin
                    if (beat) begin
                        if (hold_cnt == holdoff_q - ONE) begin
                            state    <= cfg_enable ? ARMED : IDLE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axi_fifo_flop2 #(
        .WIDTH (SAMPLE_W)
    ) u_out_reg (
        .clk     (ce_clk),
        .rst     (ce_rst),
        .up_dat  (s_axis_tdata),
        .up_last (fwd_last),
        .up_vld  (fwd_vld),
        .up_rdy  (s_axis_tready),
        .dn_dat  (m_axis_tdata),
        .dn_last (m_axis_tlast),
        .dn_vld  (m_axis_tvalid),
        .dn_rdy  (m_axis_tready)
    );

endmodule

// File: tb/tb_schmidl_cox_frame_ctrl.sv
// Bench for schmidl_cox_frame_ctrl: directed table rows, corner sequences and random sessions.
module tb_schmidl_cox_frame_ctrl;

    localparam logic [31:0] THR  = 32'h0020_0000;
    localparam int          MINP = 16;
    localparam int          MAXP = 1024;

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
    } beat_t;

    typedef struct {
        int size;
        int hold;
        int nlow;
        int nhigh;
        int ntail;
        bit rnd_rdy;
        bit rnd_gap;
        int exp_frames;
        int exp_beats;
    } vec_t;

    logic        ce_clk;
    logic        ce_rst;
    logic        cfg_enable;
    logic [15:0] cfg_packet_size;
    logic [31:0] cfg_threshold;
    logic [15:0] cfg_holdoff;
    logic [31:0] s_tdata;
    logic [31:0] s_tuser;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        det_pulse;
    logic        busy;
    logic [31:0] frame_count;

    int    checks = 0;
    int    errors = 0;
    bit    rdy_rand = 0;
    int    sess_size = 0;
    int    fc_exp = 0;

    logic [31:0] stim[$];
    logic [31:0] in_dat[$];
    logic [31:0] in_met[$];
    beat_t       exp_q[$];

    beat_t       out_q[$];
    int          det_seen = 0;
    int          hold_viol = 0;
    int          det_no_vld = 0;
    bit          prev_stall = 0;
    beat_t       prev_beat;

    schmidl_cox_frame_ctrl #(
        .MIN_PLATEAU (MINP),
        .MAX_PLATEAU (MAXP),
        .CNT_W       (16)
    ) dut (
        .ce_clk          (ce_clk),
        .ce_rst          (ce_rst),
        .cfg_enable      (cfg_enable),
        .cfg_packet_size (cfg_packet_size),
        .cfg_threshold   (cfg_threshold),
        .cfg_holdoff     (cfg_holdoff),
        .s_axis_tdata    (s_tdata),
        .s_axis_tuser    (s_tuser),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tlast    (m_tlast),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .det_pulse       (det_pulse),
        .busy            (busy),
        .frame_count     (frame_count)
    );

    initial begin
        ce_clk = 1'b0;
        forever #5 ce_clk = ~ce_clk;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge ce_clk);
            #1;
            m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time budget exceeded, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Observes the handshakes that the next rising edge will complete.
    always @(negedge ce_clk) begin
        if (ce_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(m_tvalid && m_tdata == prev_beat.dat && m_tlast == prev_beat.last))
                hold_viol++;
            if (m_tvalid && m_tready)
                out_q.push_back('{dat: m_tdata, last: m_tlast});
            if (det_pulse) begin
                det_seen++;
                if (sess_size != 0 && !m_tvalid)
                    det_no_vld++;
            end
            prev_stall     = m_tvalid && !m_tready;
            prev_beat.dat  = m_tdata;
            prev_beat.last = m_tlast;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lo_met();
        logic [31:0] v;
        v = ($urandom_range(0, 3) == 0) ? THR - 32'd1 : 32'($urandom_range(0, 32'h001f_ffff));
        return v;
    endfunction

    function automatic logic [31:0] hi_met();
        logic [31:0] v;
        v = ($urandom_range(0, 3) == 0) ? THR : THR + 32'($urandom_range(0, 32'h00ff_ffff));
        return v;
    endfunction

    task automatic build(input int nlow, input int nhigh, input int ntail);
        stim.delete();
        for (int k = 0; k < nlow; k++)  stim.push_back(lo_met());
        for (int k = 0; k < nhigh; k++) stim.push_back(hi_met());
        for (int k = 0; k < ntail; k++) stim.push_back(lo_met());
    endtask

    task automatic apply_reset();
        ce_rst     = 1'b1;
        cfg_enable = 1'b0;
        s_tvalid   = 1'b0;
        repeat (2) begin
            @(posedge ce_clk);
            #1;
        end
        ce_rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] met, input bit gap);
        int guard;
        if (gap && $urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            @(posedge ce_clk);
            #1;
        end
        s_tdata  = $urandom;
        s_tuser  = met;
        s_tvalid = 1'b1;
        guard    = 0;
        @(negedge ce_clk);
        while (!s_tready && guard < 1000) begin
            @(negedge ce_clk);
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_axis_tready low for %0d cycles, required high", guard);
        end
        in_dat.push_back(s_tdata);
        in_met.push_back(met);
        @(posedge ce_clk);
        #1;
    endtask

    // Scans the accepted beat stream for plateaus using the detection rules directly.
    task automatic model(input int size, input int hold, output int ndet);
        int    i, s, len, a, n;
        beat_t b;
        exp_q.delete();
        ndet = 0;
        n    = in_met.size();
        i    = 0;
        while (i < n) begin
            s = i;
            while (s < n && in_met[s] < THR) s++;
            if (s >= n) break;
            len = 0;
            while (s + len < n && in_met[s + len] >= THR && len < MAXP) len++;
            if (len >= MAXP) begin
                a = s + MAXP - 1;
            end else if (s + len >= n) begin
                break;
            end else if (len < MINP) begin
                i = s + len + 1;
                continue;
            end else begin
                a = s + len;
            end
            ndet++;
            for (int k = 0; k < size && a + k < n; k++) begin
                b.dat  = in_dat[a + k];
                b.last = (k == size - 1);
                exp_q.push_back(b);
            end
            i = a + ((size == 0) ? 1 : size) + hold;
        end
    endtask

    task automatic session(input string tag, input int size, input int hold, input bit rnd_rdy,
                           input bit rnd_gap, input bit do_reset, input int chg_at,
                           input int exp_frames, input int exp_beats);
        int ob, db, hb, nb, ndet, n_out;
        if (do_reset) begin
            apply_reset();
            fc_exp = 0;
        end
        sess_size       = size;
        cfg_packet_size = 16'(size);
        cfg_holdoff     = 16'(hold);
        cfg_threshold   = THR;
        cfg_enable      = 1'b1;
        @(posedge ce_clk);
        #1;
        in_dat.delete();
        in_met.delete();
        ob = out_q.size();
        db = det_seen;
        hb = hold_viol;
        nb = det_no_vld;
        rdy_rand = rnd_rdy;
        for (int k = 0; k < stim.size(); k++) begin
            if (k == chg_at) begin
                cfg_packet_size = 16'd4;
                cfg_enable      = 1'b0;
            end
            send(stim[k], rnd_gap);
        end
        s_tvalid = 1'b0;
        rdy_rand = 1'b0;
        repeat (12) begin
            @(posedge ce_clk);
            #1;
        end
        model(size, hold, ndet);
        fc_exp += ndet;
        n_out = out_q.size() - ob;
        chk({tag, "_det_model"}, det_seen - db, ndet);
        if (exp_frames >= 0) chk({tag, "_det_table"}, det_seen - db, exp_frames);
        chk({tag, "_beats_model"}, n_out, exp_q.size());
        if (exp_beats >= 0) chk({tag, "_beats_table"}, n_out, exp_beats);
        for (int k = 0; k < exp_q.size() && k < n_out; k++) begin
            checks++;
            if (out_q[ob + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s_beat%0d: got dat=0x%0h last=%0b expected dat=0x%0h last=%0b",
                         tag, k, out_q[ob + k].dat, out_q[ob + k].last, exp_q[k].dat, exp_q[k].last);
            end
        end
        chk({tag, "_frame_count"}, frame_count, fc_exp);
        chk({tag, "_hold_stable_viol"}, hold_viol - hb, 0);
        chk({tag, "_pulse_without_valid"}, det_no_vld - nb, 0);
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{8,  4, 10, 20,   30,  0, 0, 1, 8};
        tbl[1] = '{8,  4, 10, 15,   30,  0, 0, 0, 0};
        tbl[2] = '{8,  4, 10, 16,   30,  0, 0, 1, 8};
        tbl[3] = '{8,  4, 10, 2000, 30,  0, 0, 2, 16};
        tbl[4] = '{64, 4, 10, 40,   100, 1, 1, 1, 64};
        tbl[5] = '{0,  4, 10, 20,   30,  0, 0, 1, 0};
        tbl[6] = '{1,  0, 10, 20,   30,  1, 0, 1, 1};
        tbl[7] = '{4,  2, 10, 1024, 30,  0, 0, 1, 4};
        tbl[8] = '{4,  2, 10, 1023, 30,  1, 1, 1, 4};

        ce_rst          = 1'b1;
        cfg_enable      = 1'b0;
        cfg_packet_size = 16'd0;
        cfg_threshold   = 32'd0;
        cfg_holdoff     = 16'd0;
        s_tdata         = 32'd0;
        s_tuser         = 32'd0;
        s_tvalid        = 1'b0;
        #1;
        apply_reset();

        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_det_pulse", 32'(det_pulse), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd1);

        for (int r = 0; r < 9; r++) begin
            build(tbl[r].nlow, tbl[r].nhigh, tbl[r].ntail);
            session($sformatf("row%0d", r), tbl[r].size, tbl[r].hold, tbl[r].rnd_rdy,
                    tbl[r].rnd_gap, 1'b1, -1, tbl[r].exp_frames, tbl[r].exp_beats);
        end

        // Size rewritten mid-capture: current frame keeps 8, next enable latches 4.
        build(10, 20, 40);
        session("cfg_a", 8, 2, 1'b0, 1'b0, 1'b1, 33, 1, 8);
        chk("cfg_a_idle_busy", 32'(busy), 32'd0);
        build(10, 20, 10);
        session("cfg_b", 4, 2, 1'b0, 1'b0, 1'b0, -1, 1, 4);
        chk("cfg_b_frame_count", frame_count, 32'd2);

        for (int r = 0; r < 4; r++) begin
            stim.delete();
            while (stim.size() < 300) begin
                int nl, nh;
                nl = $urandom_range(1, 30);
                nh = $urandom_range(1, 40);
                for (int k = 0; k < nl; k++) stim.push_back(lo_met());
                for (int k = 0; k < nh; k++) stim.push_back(hi_met());
            end
            for (int k = 0; k < 40; k++) stim.push_back(lo_met());
            session($sformatf("rnd%0d", r), $urandom_range(0, 20), $urandom_range(0, 6),
                    1'b1, 1'b1, 1'b1, -1, -1, -1);
        end

        // Reset while a 64-sample frame is being captured.
        apply_reset();
        sess_size       = 64;
        cfg_packet_size = 16'd64;
        cfg_holdoff     = 16'd4;
        cfg_threshold   = THR;
        cfg_enable      = 1'b1;
        @(posedge ce_clk);
        #1;
        build(10, 20, 5);
        for (int k = 0; k < stim.size(); k++) send(stim[k], 1'b0);
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        chk("midrst_pre_frame_count", frame_count, 32'd1);
        chk("midrst_pre_m_tvalid", 32'(m_tvalid), 32'd1);
        ce_rst   = 1'b1;
        s_tvalid = 1'b0;
        @(posedge ce_clk);
        #1;
        chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_count", frame_count, 32'd0);
        chk("midrst_det_pulse", 32'(det_pulse), 32'd0);
        chk("midrst_s_tready", 32'(s_tready), 32'd1);
        ce_rst     = 1'b0;
        cfg_enable = 1'b0;
        repeat (3) begin
            @(posedge ce_clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
